// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: next-PC sequencer for the fetch stage.
//   Turns ID-stage control-flow events into a PC-load enable and a 2-bit
//   next-PC select. It also owns the return-address stack that supplies
//   pop_addr, and raises a one-cycle flush on every redirect.
//
// Parameters:
//   ADDR_W     instruction address width
//   RAS_DEPTH  return-address stack entries (power of 2, >= 2)
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   stall           hold PC and ignore ID events this cycle
//   halt, resume    enter / leave HALT
//   br_taken, jmp, call, ret, ret_addr   ID control-flow events
//   ld_pc           PC load enable
//   inst_sel        0=PC+1, 1=branch target, 2=pop_addr, 3=jump target
//   pop_addr        current RAS top (0 when empty)
//   flush           squash the IF/ID instruction (redirect cycle)
//   ras_cnt         RAS occupancy
//   halted          high while in HALT
//   ras_err         (RAS_TRAP_EN only) sticky RAS overflow/underflow flag
//
// Build option: define RAS_TRAP_EN to trap on RAS overflow/underflow
// instead of overwriting the oldest entry / redirecting to address 0.
module fetch_seq_ctrl #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         halt,
    input  logic                         resume,
    input  logic                         br_taken,
    input  logic                         jmp,
    input  logic                         call,
    input  logic                         ret,
    input  logic [ADDR_W-1:0]            ret_addr,
    output logic                         ld_pc,
    output logic [1:0]                   inst_sel,
    output logic [ADDR_W-1:0]            pop_addr,
    output logic                         flush,
    output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
    output logic                         halted
`ifdef RAS_TRAP_EN
    ,output logic                        ras_err
`endif
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_SQUASH,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  sp;        // next write slot; top is sp-1
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  cnt;
    logic              ras_empty;
    logic              ras_full;
    logic              mem_we;

    logic              ld_c;
    logic [1:0]        sel_c;
    logic              flush_c;
    logic              do_push;
    logic              do_pop;
`ifdef RAS_TRAP_EN
    logic              trap_set;
    logic              err;
`endif

    assign top_idx   = sp - 1'b1;
    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == CNT_W'(RAS_DEPTH));

    always_comb begin
        state_nxt = state;
        ld_c      = 1'b0;
        sel_c     = 2'd0;
        flush_c   = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
`ifdef RAS_TRAP_EN
        trap_set  = 1'b0;
`endif
        case (state)
            S_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_nxt = S_HALT;
                    end else if (ret) begin
`ifdef RAS_TRAP_EN
                        if (ras_empty) begin
                            trap_set  = 1'b1;
                            state_nxt = S_HALT;
                        end else
`endif
                        begin
                            ld_c      = 1'b1;
                            sel_c     = 2'd2;
                            flush_c   = 1'b1;
                            do_pop    = 1'b1;
                            state_nxt = S_SQUASH;
                        end
                    end else if (call) begin
                        ld_c      = 1'b1;
                        sel_c     = 2'd3;
                        flush_c   = 1'b1;
                        do_push   = 1'b1;
                        state_nxt = S_SQUASH;
                    end else if (jmp) begin
                        ld_c      = 1'b1;
                        sel_c     = 2'd3;
                        flush_c   = 1'b1;
                        state_nxt = S_SQUASH;
                    end else if (br_taken) begin
                        ld_c      = 1'b1;
                        sel_c     = 2'd1;
                        flush_c   = 1'b1;
                        state_nxt = S_SQUASH;
                    end else begin
                        ld_c = 1'b1;
                    end
                end
            end
            S_SQUASH: begin
                ld_c      = !stall;
                state_nxt = S_RUN;
            end
            S_HALT: begin
                if (resume) state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, even before the
    // first reset edge has cleared the registers.
    assign ld_pc    = rst && ld_c;
    assign inst_sel = rst ? sel_c : 2'd0;
    assign flush    = rst && flush_c;
    assign halted   = rst && (state == S_HALT);
    assign pop_addr = (rst && !ras_empty) ? ras_mem[top_idx] : '0;
    assign ras_cnt  = cnt;

`ifdef RAS_TRAP_EN
    assign mem_we  = rst && do_push && !ras_full;
    assign ras_err = err;
`else
    // Writing at sp when full lands on the oldest entry, so the circular
    // buffer overwrites it without extra logic.
    assign mem_we  = rst && do_push;
`endif

    always_ff @(posedge clk) begin
        if (mem_we) ras_mem[sp] <= ret_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_RUN;
            sp    <= '0;
            cnt   <= '0;
`ifdef RAS_TRAP_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (do_push) begin
`ifdef RAS_TRAP_EN
                if (ras_full) begin
                    err <= 1'b1;
                end else begin
                    sp  <= sp + 1'b1;
                    cnt <= cnt + 1'b1;
                end
`else
                sp <= sp + 1'b1;
                if (!ras_full) cnt <= cnt + 1'b1;
`endif
            end else if (do_pop && !ras_empty) begin
                sp  <= sp - 1'b1;
                cnt <= cnt - 1'b1;
            end
`ifdef RAS_TRAP_EN
            if (trap_set) err <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
module tb_fetch_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        stall, halt, resume, br_taken, jmp, call, ret;
    logic [11:0] ret_addr;
    logic        ld_pc;
    logic [1:0]  inst_sel;
    logic [11:0] pop_addr;
    logic        flush;
    logic [3:0]  ras_cnt;
    logic        halted;
`ifdef RAS_TRAP_EN
    logic        ras_err;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    fetch_seq_ctrl #(.ADDR_W(12), .RAS_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
        .br_taken(br_taken), .jmp(jmp), .call(call), .ret(ret),
        .ret_addr(ret_addr), .ld_pc(ld_pc), .inst_sel(inst_sel),
        .pop_addr(pop_addr), .flush(flush), .ras_cnt(ras_cnt), .halted(halted)
`ifdef RAS_TRAP_EN
        , .ras_err(ras_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // event vector bits: {stall, halt, resume, ret, call, jmp, br_taken}
    localparam logic [6:0] EV_NONE   = 7'b0000000;
    localparam logic [6:0] EV_STALL  = 7'b1000000;
    localparam logic [6:0] EV_HALT   = 7'b0100000;
    localparam logic [6:0] EV_RESUME = 7'b0010000;
    localparam logic [6:0] EV_RET    = 7'b0001000;
    localparam logic [6:0] EV_CALL   = 7'b0000100;
    localparam logic [6:0] EV_JMP    = 7'b0000010;
    localparam logic [6:0] EV_BR     = 7'b0000001;

    typedef struct {
        logic [20:0] v;   // {ld_pc, inst_sel, flush, pop_addr, ras_cnt, halted}
        string       nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Monitor: one output sample per cycle, compared against the queue head.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [20:0] act;
            e   = q.pop_front();
            act = {ld_pc, inst_sel, flush, pop_addr, ras_cnt, halted};
            checks++;
            if (act !== e.v)
                $display("FAIL %s: got ld=%b sel=%0d fl=%b pa=%h cnt=%0d h=%b, want ld=%b sel=%0d fl=%b pa=%h cnt=%0d h=%b",
                         e.nm, act[20], act[19:18], act[17], act[16:5], act[4:1], act[0],
                         e.v[20], e.v[19:18], e.v[17], e.v[16:5], e.v[4:1], e.v[0]);
            else
                passed++;
        end
    end

    task automatic cyc(input logic [6:0] ev, input logic [11:0] ra,
                       input logic e_ld, input logic [1:0] e_sel, input logic e_fl,
                       input logic [11:0] e_pa, input logic [3:0] e_cnt, input logic e_h,
                       input string nm);
        exp_t e;
        {stall, halt, resume, ret, call, jmp, br_taken} = ev;
        ret_addr = ra;
        e.v  = {e_ld, e_sel, e_fl, e_pa, e_cnt, e_h};
        e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned newest;
        rst = 1'b0;
        {stall, halt, resume, ret, call, jmp, br_taken} = EV_NONE;
        ret_addr = '0;
        @(posedge clk);
        #1;

        // 1. reset, then free-running sequential fetch
        cyc(EV_JMP,  12'h0, 0, 0, 0, 12'h0, 0, 0, "reset_0");
        cyc(EV_NONE, 12'h0, 0, 0, 0, 12'h0, 0, 0, "reset_1");
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc(EV_NONE, 12'h0, 1, 0, 0, 12'h0, 0, 0, "run_seq");

        // 2. call then ret
        cyc(EV_CALL, 12'h015, 1, 3, 1, 12'h000, 0, 0, "call");
        cyc(EV_NONE, 12'h0,   1, 0, 0, 12'h015, 1, 0, "call_squash");
        cyc(EV_NONE, 12'h0,   1, 0, 0, 12'h015, 1, 0, "call_run");
        cyc(EV_RET,  12'h0,   1, 2, 1, 12'h015, 1, 0, "ret");
        cyc(EV_NONE, 12'h0,   1, 0, 0, 12'h000, 0, 0, "ret_squash");

        // 3. priority ret > jmp > br, jmp in SQUASH ignored
        cyc(EV_CALL, 12'h0A0, 1, 3, 1, 12'h000, 0, 0, "call_b");
        cyc(EV_NONE, 12'h0,   1, 0, 0, 12'h0A0, 1, 0, "call_b_squash");
        cyc(EV_RET | EV_JMP | EV_BR, 12'h0, 1, 2, 1, 12'h0A0, 1, 0, "prio_ret");
        cyc(EV_JMP,  12'h0,   1, 0, 0, 12'h000, 0, 0, "squash_ignores_jmp");
        cyc(EV_NONE, 12'h0,   1, 0, 0, 12'h000, 0, 0, "run_after_prio");

        // 4. stall holds a branch; stall in SQUASH blocks the load
        cyc(EV_STALL | EV_BR, 12'h0, 0, 0, 0, 12'h0, 0, 0, "stall_br");
        cyc(EV_STALL | EV_BR, 12'h0, 0, 0, 0, 12'h0, 0, 0, "stall_br2");
        cyc(EV_BR,    12'h0, 1, 1, 1, 12'h0, 0, 0, "br_taken");
        cyc(EV_STALL, 12'h0, 0, 0, 0, 12'h0, 0, 0, "squash_stall");
        cyc(EV_NONE,  12'h0, 1, 0, 0, 12'h0, 0, 0, "run_after_br");

        // 5. overflow the stack with 9 calls, then drain with 9 rets
        for (int i = 1; i <= 9; i++) begin
            cyc(EV_CALL, 12'(32'h100 + i), 1, 3, 1,
                (i == 1) ? 12'h000 : 12'(32'h100 + i - 1), 4'(i - 1), 0, "call_fill");
            cyc(EV_NONE, 12'h0, 1, 0, 0,
                (TRAP && i == 9) ? 12'h108 : 12'(32'h100 + i), 4'((i > 8) ? 8 : i), 0, "call_fill_squash");
        end
        newest = TRAP ? 32'h108 : 32'h109;
        for (int j = 0; j < 8; j++) begin
            cyc(EV_RET,  12'h0, 1, 2, 1, 12'(newest - j), 4'(8 - j), 0, "ret_drain");
            cyc(EV_NONE, 12'h0, 1, 0, 0, (j < 7) ? 12'(newest - j - 1) : 12'h000,
                4'(7 - j), 0, "ret_drain_squash");
        end
        if (TRAP) begin
            cyc(EV_RET,    12'h0, 0, 0, 0, 12'h0, 0, 0, "ret_empty_trap");
            cyc(EV_RESUME, 12'h0, 0, 0, 0, 12'h0, 0, 1, "trap_halted");
        end else begin
            cyc(EV_RET,  12'h0, 1, 2, 1, 12'h0, 0, 0, "ret_empty");
            cyc(EV_NONE, 12'h0, 1, 0, 0, 12'h0, 0, 0, "ret_empty_squash");
        end
`ifdef RAS_TRAP_EN
        checks++;
        if (ras_err !== 1'b1)
            $display("FAIL ras_err_sticky: got %b, want 1", ras_err);
        else
            passed++;
`endif
        cyc(EV_NONE, 12'h0, 1, 0, 0, 12'h0, 0, 0, "run_after_drain");

        // 6. halt / resume, then reset while halted
        cyc(EV_CALL,   12'h2AA, 1, 3, 1, 12'h000, 0, 0, "call_c");
        cyc(EV_NONE,   12'h0,   1, 0, 0, 12'h2AA, 1, 0, "call_c_squash");
        cyc(EV_HALT,   12'h0,   0, 0, 0, 12'h2AA, 1, 0, "halt_enter");
        cyc(EV_JMP,    12'h0,   0, 0, 0, 12'h2AA, 1, 1, "halt_ignores_jmp");
        cyc(EV_NONE,   12'h0,   0, 0, 0, 12'h2AA, 1, 1, "halt_hold");
        cyc(EV_RESUME, 12'h0,   0, 0, 0, 12'h2AA, 1, 1, "resume");
        cyc(EV_NONE,   12'h0,   1, 0, 0, 12'h2AA, 1, 0, "restart");
        cyc(EV_HALT,   12'h0,   0, 0, 0, 12'h2AA, 1, 0, "halt_again");
        cyc(EV_NONE,   12'h0,   0, 0, 0, 12'h2AA, 1, 1, "halt_again_hold");
        rst = 1'b0;
        cyc(EV_NONE,   12'h0,   0, 0, 0, 12'h000, 1, 0, "reset_in_halt");
        rst = 1'b1;
        cyc(EV_NONE,   12'h0,   1, 0, 0, 12'h000, 0, 0, "post_reset");
        cyc(EV_BR,     12'h0,   1, 1, 1, 12'h000, 0, 0, "post_reset_br");

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
